// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-port memory arbiter.
// Imported by the picker and the arbiter top.
package mem_arb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    typedef enum logic {
        ARB_READ,
        ARB_WRITE
    } arb_op_t;

    function automatic int clog2_ports(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational winner selection: round-robin after last grant,
// or fixed priority with port 0 highest.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int FIXED_PRIO = 0,
    parameter int IW         = clog2_ports(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_active,
    input  logic [IW-1:0]        i_last,
    output logic [IW-1:0]        o_winner,
    output logic                 o_any
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (FIXED_PRIO != 0) w_idx = k;
            else w_idx = (int'(i_last) + 1 + k) % NUM_PORTS;
            if (!w_found && i_active[w_idx]) begin
                o_winner = IW'(w_idx);
                w_found  = 1'b1;
            end
        end
    end

    assign o_any = |i_active;

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port arbiter onto one memory port; one transaction in flight,
// request fields latched at grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    localparam int BE_W      = DATA_W / 8,
    localparam int IW        = clog2_ports(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_read,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*BE_W-1:0]   req_byte_enable,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        req_resp,
    output logic [DATA_W-1:0]           req_rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [BE_W-1:0]             mem_byte_enable,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_resp,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [IW-1:0]               grant_idx,
    output logic                        busy
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    arb_op_t             r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic [IW-1:0]       r_grant;
    logic [IW-1:0]       r_last;
    logic [IW-1:0]       w_winner;
    logic                w_any;
    logic                w_done;
    logic [NUM_PORTS-1:0] w_active;
    logic [NUM_PORTS-1:0] w_resp;

    assign w_active = req_read | req_write;
    assign w_done   = (r_state == BUSY) && mem_resp;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .FIXED_PRIO(FIXED_PRIO),
        .IW        (IW)
    ) u_picker (
        .i_active(w_active),
        .i_last  (r_last),
        .o_winner(w_winner),
        .o_any   (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_any) w_state_nxt = BUSY;
            BUSY: if (mem_resp) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_op    <= ARB_READ;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_grant <= '0;
            r_last  <= IW'(NUM_PORTS - 1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_any) begin
                r_grant <= w_winner;
                r_addr  <= req_address[int'(w_winner)*ADDR_W +: ADDR_W];
                r_wdata <= req_wdata[int'(w_winner)*DATA_W +: DATA_W];
                r_be    <= req_byte_enable[int'(w_winner)*BE_W +: BE_W];
                // a port raising both strobes is served as a write
                r_op    <= req_write[w_winner] ? ARB_WRITE : ARB_READ;
            end
            if (w_done) r_last <= r_grant;
        end
    end

    always_comb begin
        w_resp = '0;
        if (w_done) w_resp[r_grant] = 1'b1;
    end

    assign req_resp        = w_resp;
    assign req_rdata       = mem_rdata;
    assign mem_read        = (r_state == BUSY) && (r_op == ARB_READ);
    assign mem_write       = (r_state == BUSY) && (r_op == ARB_WRITE);
    assign mem_address     = r_addr;
    assign mem_wdata       = r_wdata;
    assign mem_byte_enable = r_be;
    assign grant_idx       = r_grant;
    assign busy            = (r_state == BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench: 2-port round-robin and
// 4-port fixed-priority arbiter instances.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    logic [1:0]  a_rd, a_wr, a_resp;
    logic [7:0]  a_be;
    logic [63:0] a_addr, a_wd;
    logic [31:0] a_rdata, a_maddr, a_mwd, a_mrdata;
    logic        a_mrd, a_mwr, a_mresp, a_busy, a_gnt;
    logic [3:0]  a_mbe;

    logic [3:0]   b_rd, b_wr, b_resp, b_mbe;
    logic [15:0]  b_be;
    logic [127:0] b_addr, b_wd;
    logic [31:0]  b_rdata, b_maddr, b_mwd, b_mrdata;
    logic         b_mrd, b_mwr, b_mresp, b_busy;
    logic [1:0]   b_gnt;

    mem_port_arbiter #(.NUM_PORTS(2), .FIXED_PRIO(0)) u_a (
        .clk(clk), .rst(rst),
        .req_read(a_rd), .req_write(a_wr),
        .req_byte_enable(a_be), .req_address(a_addr),
        .req_wdata(a_wd), .req_resp(a_resp),
        .req_rdata(a_rdata), .mem_read(a_mrd),
        .mem_write(a_mwr), .mem_byte_enable(a_mbe),
        .mem_address(a_maddr), .mem_wdata(a_mwd),
        .mem_resp(a_mresp), .mem_rdata(a_mrdata),
        .grant_idx(a_gnt), .busy(a_busy)
    );

    mem_port_arbiter #(.NUM_PORTS(4), .FIXED_PRIO(1)) u_b (
        .clk(clk), .rst(rst),
        .req_read(b_rd), .req_write(b_wr),
        .req_byte_enable(b_be), .req_address(b_addr),
        .req_wdata(b_wd), .req_resp(b_resp),
        .req_rdata(b_rdata), .mem_read(b_mrd),
        .mem_write(b_mwr), .mem_byte_enable(b_mbe),
        .mem_address(b_maddr), .mem_wdata(b_mwd),
        .mem_resp(b_mresp), .mem_rdata(b_mrdata),
        .grant_idx(b_gnt), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({a_mrd, a_mwr, a_busy, a_resp} !== 5'b0) begin
            errs++;
            $display("FAIL reset_ctl_a: got %b want 00000",
                     {a_mrd, a_mwr, a_busy, a_resp});
        end
        checks++;
        if ({a_maddr, a_mwd, a_mbe, a_gnt} !== 69'b0) begin
            errs++;
            $display("FAIL reset_data_a: got %h %h %h %h want 0",
                     a_maddr, a_mwd, a_mbe, a_gnt);
        end
        checks++;
        if ({b_mrd, b_mwr, b_busy, b_resp, b_gnt} !== 9'b0) begin
            errs++;
            $display("FAIL reset_b: got %b want 0",
                     {b_mrd, b_mwr, b_busy, b_resp, b_gnt});
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        a_addr[63:32] = 32'h0000_0040;
        a_rd = 2'b10;
        tick();
        checks++;
        if ({a_mrd, a_mwr, a_maddr} !== {2'b10, 32'h40}) begin
            errs++;
            $display("FAIL read_issue: got rd=%b wr=%b addr=%h want 1 0 40",
                     a_mrd, a_mwr, a_maddr);
        end
        checks++;
        if (a_resp !== 2'b00) begin
            errs++;
            $display("FAIL read_early_resp: got %b want 00", a_resp);
        end
        a_mresp = 1'b1;
        a_mrdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({a_resp, a_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            errs++;
            $display("FAIL read_resp: got %b %h want 10 deadbeef",
                     a_resp, a_rdata);
        end
        tick();
        a_rd = 2'b00;
        a_mresp = 1'b0;
        #1;
        checks++;
        if ({a_resp, a_mrd, a_busy} !== 4'b0) begin
            errs++;
            $display("FAIL read_done: got %b want 0000",
                     {a_resp, a_mrd, a_busy});
        end
    endtask

    task automatic test_round_robin();
        logic exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] oh;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        a_rd = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({a_busy, a_gnt} !== {1'b1, exp_g[i]}) begin
                errs++;
                $display("FAIL rr_grant%0d: got busy=%b g=%b want 1 %b",
                         i, a_busy, a_gnt, exp_g[i]);
            end
            a_mresp = 1'b1;
            #1;
            oh = exp_g[i] ? 2'b10 : 2'b01;
            checks++;
            if (a_resp !== oh) begin
                errs++;
                $display("FAIL rr_resp%0d: got %b want %b", i, a_resp, oh);
            end
            tick();
            a_mresp = 1'b0;
            #1;
            checks++;
            if ({a_busy, a_resp} !== 3'b0) begin
                errs++;
                $display("FAIL rr_bubble%0d: got %b want 000",
                         i, {a_busy, a_resp});
            end
        end
        a_rd = 2'b00;
        tick();
    endtask

    task automatic test_fixed_prio();
        logic [1:0] exp_g [3] = '{2'd0, 2'd2, 2'd3};
        b_rd = 4'b1100;
        tick();
        checks++;
        if ({b_busy, b_gnt} !== 3'b110) begin
            errs++;
            $display("FAIL fp_first: got %b %0d want 1 2", b_busy, b_gnt);
        end
        b_rd[0] = 1'b1;
        tick();
        b_mresp = 1'b1;
        #1;
        checks++;
        if (b_resp !== 4'b0100) begin
            errs++;
            $display("FAIL fp_first_resp: got %b want 0100", b_resp);
        end
        tick();
        b_mresp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({b_busy, b_gnt} !== {1'b1, exp_g[i]}) begin
                errs++;
                $display("FAIL fp_grant%0d: got %b %0d want 1 %0d",
                         i, b_busy, b_gnt, exp_g[i]);
            end
            b_mresp = 1'b1;
            tick();
            b_mresp = 1'b0;
            b_rd[exp_g[i]] = 1'b0;
        end
        tick();
        checks++;
        if (b_busy !== 1'b0) begin
            errs++;
            $display("FAIL fp_idle: got %b want 0", b_busy);
        end
    endtask

    task automatic test_write();
        a_addr[31:0] = 32'h100;
        a_wd[31:0] = 32'h1234_5678;
        a_be[3:0] = 4'b0011;
        a_wr = 2'b01;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({a_mwr, a_mrd, a_maddr, a_mwd, a_mbe} !==
                {2'b10, 32'h100, 32'h1234_5678, 4'b0011}) begin
                errs++;
                $display("FAIL write_hold%0d: got %b%b %h %h %b", i,
                         a_mwr, a_mrd, a_maddr, a_mwd, a_mbe);
            end
            if (i < 2) tick();
        end
        a_mresp = 1'b1;
        #1;
        checks++;
        if (a_resp !== 2'b01) begin
            errs++;
            $display("FAIL write_resp: got %b want 01", a_resp);
        end
        tick();
        a_mresp = 1'b0;
        a_wr = 2'b00;
        tick();
    endtask

    task automatic test_input_hold();
        a_addr[31:0] = 32'h200;
        a_rd = 2'b01;
        tick();
        a_addr[31:0] = 32'h300;
        a_rd = 2'b00;
        a_wr = 2'b01;
        tick();
        checks++;
        if ({a_maddr, a_mrd, a_mwr} !== {32'h200, 2'b10}) begin
            errs++;
            $display("FAIL hold_addr: got %h %b%b want 200 10",
                     a_maddr, a_mrd, a_mwr);
        end
        a_wr = 2'b00;
        a_mresp = 1'b1;
        #1;
        checks++;
        if (a_resp !== 2'b01) begin
            errs++;
            $display("FAIL hold_dropped_resp: got %b want 01", a_resp);
        end
        tick();
        a_mresp = 1'b0;
        tick();
    endtask

    task automatic test_both_strobes();
        a_rd = 2'b10;
        a_wr = 2'b10;
        tick();
        checks++;
        if ({a_mwr, a_mrd, a_gnt} !== 3'b101) begin
            errs++;
            $display("FAIL both_as_write: got %b want 101",
                     {a_mwr, a_mrd, a_gnt});
        end
        a_mresp = 1'b1;
        tick();
        a_mresp = 1'b0;
        a_rd = 2'b00;
        a_wr = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        a_addr[31:0] = 32'h80;
        a_rd = 2'b01;
        tick();
        checks++;
        if (a_mrd !== 1'b1) begin
            errs++;
            $display("FAIL rmid_start: got %b want 1", a_mrd);
        end
        a_mresp = 1'b1;
        rst = 1'b0;
        #1;
        checks++;
        if ({a_mrd, a_busy, a_resp} !== 4'b0) begin
            errs++;
            $display("FAIL rmid_async: got %b want 0000",
                     {a_mrd, a_busy, a_resp});
        end
        tick();
        rst = 1'b1;
        a_rd = 2'b00;
        tick();
        checks++;
        if ({a_mrd, a_busy, a_resp} !== 4'b0) begin
            errs++;
            $display("FAIL rmid_stale_resp: got %b want 0000",
                     {a_mrd, a_busy, a_resp});
        end
        a_mresp = 1'b0;
        a_rd = 2'b11;
        tick();
        checks++;
        if ({a_busy, a_gnt} !== 2'b10) begin
            errs++;
            $display("FAIL rmid_next_grant: got %b %b want 1 0",
                     a_busy, a_gnt);
        end
        a_mresp = 1'b1;
        tick();
        a_mresp = 1'b0;
        a_rd = 2'b00;
        tick();
    endtask

    initial begin
        a_rd = '0; a_wr = '0; a_be = '0; a_addr = '0; a_wd = '0;
        a_mresp = 1'b0; a_mrdata = '0;
        b_rd = '0; b_wr = '0; b_be = '0; b_addr = '0; b_wd = '0;
        b_mresp = 1'b0; b_mrdata = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_prio();
        test_write();
        test_input_hold();
        test_both_strobes();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
